accel_ball_bounce: RTL and testbench

Parametrised successor to the teeter ball-motion block. Integrates signed accelerometer tilt into per-axis fixed-point velocity and position once per physics tick. Applies a runtime-selectable wall policy (clamp, damped bounce, or wrap). Drives the sprite bottom-left coordinate to the renderer and emits wall-hit pulses for the sound/score logic.

---
 rtl/accel_ball_bounce_pkg.sv | 48 ++++
 rtl/accel_ball_bounce_if.sv | 27 ++
 rtl/ball_axis_integrator.sv | 112 +++++++++++
 rtl/accel_ball_bounce.sv | 147 ++++++++++++++
 tb/tb_accel_ball_bounce.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/accel_ball_bounce_pkg.sv
// Shared mode encodings, FSM states and fixed-point helpers for the ball-motion block.
// All helper arithmetic runs at CALC_W signed bits, wide enough for every intermediate.
package accel_ball_bounce_pkg;

  localparam int CALC_W = 32;
  typedef logic signed [CALC_W-1:0] calc_t;

  localparam logic [1:0] MODE_CLAMP  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_WRAP   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEL,
    ST_POS,
    ST_WALL,
    ST_COMMIT
  } state_e;

  // Interpret the low 'width' bits of raw as two's complement.
  function automatic calc_t sext(input logic [CALC_W-1:0] raw, input int width);
    calc_t t;
    t    = calc_t'(raw << (CALC_W - width));
    sext = t >>> (CALC_W - width);
  endfunction

  function automatic calc_t sat(input calc_t v, input int lim);
    calc_t r;
    r = v;
    if (v > calc_t'(lim)) begin
      r = calc_t'(lim);
    end else if (v < -calc_t'(lim)) begin
      r = -calc_t'(lim);
    end
    sat = r;
  endfunction

  // Bounce loss on a magnitude; tiny rebounds collapse to rest.
  function automatic calc_t damp(input calc_t m, input int shift, input int vmin);
    calc_t r;
    r = m - (m >>> shift);
    if (r < calc_t'(vmin)) begin
      r = '0;
    end
    damp = r;
  endfunction

endpackage

// File: rtl/accel_ball_bounce_if.sv
// Tilt/control inputs and sprite/pulse outputs of the ball-motion block.
// master drives tilt and controls; slave is the physics block.
interface accel_ball_bounce_if #(
  parameter int POS_W   = 10,
  parameter int ACCEL_W = 8
);
  logic signed [ACCEL_W-1:0] accel_x;
  logic signed [ACCEL_W-1:0] accel_y;
  logic [1:0]                mode;
  logic                      pause;
  logic                      recenter;
  logic [POS_W-1:0]          bl_x;
  logic [POS_W-1:0]          bl_y;
  logic                      hit_x;
  logic                      hit_y;
  logic                      update;

  modport master (
    output accel_x, accel_y, mode, pause, recenter,
    input  bl_x, bl_y, hit_x, hit_y, update
  );

  modport slave (
    input  accel_x, accel_y, mode, pause, recenter,
    output bl_x, bl_y, hit_x, hit_y, update
  );
endinterface

// File: rtl/ball_axis_integrator.sv
// One axis of ball motion: velocity integrate, position integrate, wall policy.
// Each step is a one-cycle enable from the top FSM; recenter overrides all steps.
module ball_axis_integrator
  import accel_ball_bounce_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int FRAC_W     = 8,
  parameter int ACCEL_W    = 8,
  parameter int VEL_W      = 16,
  parameter int VMAX       = 4096,
  parameter int DAMP_SHIFT = 2,
  parameter int VMIN       = 64,
  parameter int LIMIT      = 288,
  parameter int START      = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      recenter_i,
  input  logic                      vel_en_i,
  input  logic                      pos_en_i,
  input  logic                      wall_en_i,
  input  logic [1:0]                mode_i,
  input  logic signed [ACCEL_W-1:0] accel_i,
  output logic [POS_W-1:0]          pix_o,
  output logic                      hit_o
);

  localparam int    PW       = POS_W + FRAC_W + 2;
  localparam calc_t START_FP = calc_t'(START) <<< FRAC_W;
  localparam calc_t LIM_FP   = calc_t'(LIMIT) <<< FRAC_W;
  localparam calc_t SPAN_FP  = calc_t'(LIMIT + 1) <<< FRAC_W;

  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic signed [PW-1:0]    pos_q, pos_d;
  logic signed [PW-1:0]    nxt_q, nxt_d;
  logic                    hit_q, hit_d;

  calc_t nxt_w;
  calc_t vabs_w;
  calc_t vdamp_w;

  always_comb begin
    vel_d   = vel_q;
    pos_d   = pos_q;
    nxt_d   = nxt_q;
    hit_d   = hit_q;
    nxt_w   = calc_t'(nxt_q);
    vabs_w  = (vel_q < 0) ? -calc_t'(vel_q) : calc_t'(vel_q);
    vdamp_w = damp(vabs_w, DAMP_SHIFT, VMIN);

    if (recenter_i) begin
      vel_d = '0;
      pos_d = PW'(START_FP);
      nxt_d = PW'(START_FP);
      hit_d = 1'b0;
    end else if (vel_en_i) begin
      vel_d = VEL_W'(sat(calc_t'(vel_q) +
                         sext({{(CALC_W-ACCEL_W){1'b0}}, accel_i}, ACCEL_W), VMAX));
    end else if (pos_en_i) begin
      nxt_d = pos_q + PW'(vel_q);
    end else if (wall_en_i) begin
      hit_d = 1'b1;
      if (nxt_w < 0) begin
        case (mode_i)
          MODE_WRAP:   pos_d = PW'(nxt_w + SPAN_FP);
          MODE_BOUNCE: begin
            pos_d = '0;
            vel_d = VEL_W'(vdamp_w);
          end
          default: begin
            pos_d = '0;
            vel_d = '0;
          end
        endcase
      end else if (nxt_w > LIM_FP) begin
        case (mode_i)
          MODE_WRAP:   pos_d = PW'(nxt_w - SPAN_FP);
          MODE_BOUNCE: begin
            pos_d = PW'(LIM_FP);
            vel_d = VEL_W'(-vdamp_w);
          end
          default: begin
            pos_d = PW'(LIM_FP);
            vel_d = '0;
          end
        endcase
      end else begin
        // Touching exactly 0 or LIMIT is inside the playfield.
        pos_d = nxt_q;
        hit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_q <= '0;
      pos_q <= PW'(START_FP);
      nxt_q <= PW'(START_FP);
      hit_q <= 1'b0;
    end else begin
      vel_q <= vel_d;
      pos_q <= pos_d;
      nxt_q <= nxt_d;
      hit_q <= hit_d;
    end
  end

  assign pix_o = pos_q[FRAC_W +: POS_W];
  assign hit_o = hit_q;

endmodule

// File: rtl/accel_ball_bounce.sv
// Tilt-driven ball motion: tick counter, 5-state physics FSM, two axis integrators.
// Sprite position and hit/update pulses change on the COMMIT edge, 4 cycles after a tick.
module accel_ball_bounce
  import accel_ball_bounce_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int SPRITE_SIZE   = 32,
  parameter int START_X       = 100,
  parameter int START_Y       = 50,
  parameter int POS_W         = 10,
  parameter int FRAC_W        = 8,
  parameter int ACCEL_W       = 8,
  parameter int VEL_W         = 16,
  parameter int VMAX          = 4096,
  parameter int DAMP_SHIFT    = 2,
  parameter int VMIN          = 64,
  parameter int TICK_DIV      = 35293
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  accel_ball_bounce_if.slave   bus
);

  localparam int LIMIT_X = SCREEN_WIDTH - SPRITE_SIZE;
  localparam int LIMIT_Y = SCREEN_HEIGHT - SPRITE_SIZE;
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             vel_en, pos_en, wall_en, commit;

  logic [POS_W-1:0] pix_x, pix_y;
  logic             flag_x, flag_y;
  logic [POS_W-1:0] bl_x_q, bl_y_q;
  logic             hit_x_q, hit_y_q, update_q;

  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d = (bus.recenter || tick) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vel_en  = 1'b0;
    pos_en  = 1'b0;
    wall_en = 1'b0;
    commit  = 1'b0;
    if (bus.recenter) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (tick && !bus.pause) state_d = ST_VEL;
        ST_VEL:    begin vel_en  = 1'b1; state_d = ST_POS;    end
        ST_POS:    begin pos_en  = 1'b1; state_d = ST_WALL;   end
        ST_WALL:   begin wall_en = 1'b1; state_d = ST_COMMIT; end
        ST_COMMIT: begin commit  = 1'b1; state_d = ST_IDLE;   end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Wall policy is frozen per sequence; the reserved encoding behaves as clamp.
  always_comb begin
    mode_d = mode_q;
    if (state_q == ST_VEL) begin
      mode_d = (bus.mode == 2'd3) ? MODE_CLAMP : bus.mode;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_CLAMP;
    end else begin
      mode_q <= mode_d;
    end
  end

  ball_axis_integrator #(
    .POS_W(POS_W), .FRAC_W(FRAC_W), .ACCEL_W(ACCEL_W), .VEL_W(VEL_W),
    .VMAX(VMAX), .DAMP_SHIFT(DAMP_SHIFT), .VMIN(VMIN),
    .LIMIT(LIMIT_X), .START(START_X)
  ) u_axis_x (
    .clk(CLK), .rst_n(rst_n), .recenter_i(bus.recenter),
    .vel_en_i(vel_en), .pos_en_i(pos_en), .wall_en_i(wall_en),
    .mode_i(mode_q), .accel_i(bus.accel_x),
    .pix_o(pix_x), .hit_o(flag_x)
  );

  ball_axis_integrator #(
    .POS_W(POS_W), .FRAC_W(FRAC_W), .ACCEL_W(ACCEL_W), .VEL_W(VEL_W),
    .VMAX(VMAX), .DAMP_SHIFT(DAMP_SHIFT), .VMIN(VMIN),
    .LIMIT(LIMIT_Y), .START(START_Y)
  ) u_axis_y (
    .clk(CLK), .rst_n(rst_n), .recenter_i(bus.recenter),
    .vel_en_i(vel_en), .pos_en_i(pos_en), .wall_en_i(wall_en),
    .mode_i(mode_q), .accel_i(bus.accel_y),
    .pix_o(pix_y), .hit_o(flag_y)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bl_x_q   <= POS_W'(START_X);
      bl_y_q   <= POS_W'(START_Y);
      hit_x_q  <= 1'b0;
      hit_y_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      hit_x_q  <= 1'b0;
      hit_y_q  <= 1'b0;
      update_q <= 1'b0;
      if (bus.recenter) begin
        bl_x_q <= POS_W'(START_X);
        bl_y_q <= POS_W'(START_Y);
      end else if (commit) begin
        bl_x_q   <= pix_x;
        bl_y_q   <= pix_y;
        hit_x_q  <= flag_x;
        hit_y_q  <= flag_y;
        update_q <= 1'b1;
      end
    end
  end

  assign bus.bl_x   = bl_x_q;
  assign bus.bl_y   = bl_y_q;
  assign bus.hit_x  = hit_x_q;
  assign bus.hit_y  = hit_y_q;
  assign bus.update = update_q;

endmodule

// File: tb/tb_accel_ball_bounce.sv
// Directed bench for accel_ball_bounce with TICK_DIV=8: vector table plus reset/pause/recenter sequences.
module tb_accel_ball_bounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accel_ball_bounce_if #(.POS_W(10), .ACCEL_W(8)) bus ();

  accel_ball_bounce #(.TICK_DIV(8)) dut (
    .CLK(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic       rc;
    int         ax;
    int         ay;
    logic [1:0] mode;
    int         ticks;
    int         ex;
    int         ey;
    int         ehx;
    int         ehy;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_update();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.update) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL update_timeout: no update pulse within 24 cycles");
    end
  endtask

  task automatic pulse_recenter();
    bus.recenter = 1'b1;
    step(1);
    bus.recenter = 1'b0;
  endtask

  // Releases reset between edges; first commit must land on the 12th edge.
  task automatic check_release(input int idx);
    int first;
    first = -1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (bus.update && first < 0) first = e;
      if (e == 13) chk("update_width", idx, int'(bus.update), 0);
    end
    chk("first_update_edge", idx, first, 12);
  endtask

  initial begin
    int cnt;
    //            rc    ax    ay  mode ticks  ex   ey  hx hy
    vt[0]  = '{1'b1,    0,    0, 2'd0,   4, 100,  50, 0, 0};
    vt[1]  = '{1'b1,   16,    0, 2'd0,   1, 100,  50, 0, 0};
    vt[2]  = '{1'b0,   16,    0, 2'd0,  15, 108,  50, 0, 0};
    vt[3]  = '{1'b1,  127,    0, 2'd0,  27, 287,  50, 0, 0};
    vt[4]  = '{1'b0,  127,    0, 2'd0,   1, 288,  50, 1, 0};
    vt[5]  = '{1'b0,  127,    0, 2'd0,   1, 288,  50, 1, 0};
    vt[6]  = '{1'b1, -128,    0, 2'd3,  19,   5,  50, 0, 0};
    vt[7]  = '{1'b0, -128,    0, 2'd3,   1,   0,  50, 1, 0};
    vt[8]  = '{1'b1, -128,    0, 2'd2,  20, 284,  50, 1, 0};
    vt[9]  = '{1'b1,  127,    0, 2'd2,  28,  12,  50, 1, 0};
    vt[10] = '{1'b0,  127,    0, 2'd2,   4,  72,  50, 0, 0};
    vt[11] = '{1'b0,  127,    0, 2'd2,   3, 120,  50, 0, 0};
    vt[12] = '{1'b1,    0, -128, 2'd1,   8, 100,  32, 0, 0};
    vt[13] = '{1'b0,    0,    0, 2'd1,   8, 100,   0, 0, 0};
    vt[14] = '{1'b0,    0,    0, 2'd1,   1, 100,   0, 0, 1};
    vt[15] = '{1'b0,    0,    0, 2'd1,   1, 100,   3, 0, 0};
    vt[16] = '{1'b0,    0,    0, 2'd1,   1, 100,   6, 0, 0};
    vt[17] = '{1'b1,    0,  -80, 2'd1,   1, 100,  49, 0, 0};
    vt[18] = '{1'b0,    0,    0, 2'd1, 159, 100,   0, 0, 0};
    vt[19] = '{1'b0,    0,    0, 2'd1,   1, 100,   0, 0, 1};
    vt[20] = '{1'b0,    0,    0, 2'd1,  10, 100,   0, 0, 0};
    vt[21] = '{1'b1,  127,    0, 2'd1,  28, 288,  50, 1, 0};
    vt[22] = '{1'b0,    0,    0, 2'd1,   1, 277,  50, 0, 0};

    bus.accel_x  = '0;
    bus.accel_y  = '0;
    bus.mode     = 2'd0;
    bus.pause    = 1'b0;
    bus.recenter = 1'b0;
    rst_n        = 1'b0;
    step(3);
    chk("reset_bl_x", 0, int'(bus.bl_x), 100);
    chk("reset_bl_y", 0, int'(bus.bl_y), 50);
    chk("reset_pulses", 0, int'({bus.update, bus.hit_x, bus.hit_y}), 0);

    check_release(0);
    chk("idle_bl_x", 0, int'(bus.bl_x), 100);
    chk("idle_bl_y", 0, int'(bus.bl_y), 50);

    for (int v = 0; v < NV; v++) begin
      if (vt[v].rc) pulse_recenter();
      bus.accel_x = 8'(vt[v].ax);
      bus.accel_y = 8'(vt[v].ay);
      bus.mode    = vt[v].mode;
      for (int t = 0; t < vt[v].ticks; t++) wait_update();
      chk("bl_x", v, int'(bus.bl_x), vt[v].ex);
      chk("bl_y", v, int'(bus.bl_y), vt[v].ey);
      chk("hit_x", v, int'(bus.hit_x), vt[v].ehx);
      chk("hit_y", v, int'(bus.hit_y), vt[v].ehy);
      step(1);
      chk("pulse_width", v, int'({bus.update, bus.hit_x, bus.hit_y}), 0);
    end

    // Pause holds state across several ticks.
    pulse_recenter();
    bus.mode    = 2'd0;
    bus.accel_x = 8'sd127;
    bus.accel_y = '0;
    wait_update();
    chk("pause_pre_x", 0, int'(bus.bl_x), 100);
    bus.pause = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.update) cnt++;
    end
    chk("pause_updates", 0, cnt, 0);
    chk("pause_bl_x", 0, int'(bus.bl_x), 100);
    chk("pause_bl_y", 0, int'(bus.bl_y), 50);
    bus.pause = 1'b0;
    wait_update();
    chk("pause_post_x", 0, int'(bus.bl_x), 101);

    // Recenter while the next sequence is in POS aborts it.
    step(5);
    bus.recenter = 1'b1;
    step(1);
    bus.recenter = 1'b0;
    bus.accel_x  = '0;
    chk("rc_bl_x", 0, int'(bus.bl_x), 100);
    chk("rc_bl_y", 0, int'(bus.bl_y), 50);
    chk("rc_update", 0, int'(bus.update), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.update) cnt++;
    end
    chk("rc_no_commit", 0, cnt, 0);
    wait_update();
    chk("rc_vel_zero_x", 0, int'(bus.bl_x), 100);
    chk("rc_vel_zero_y", 0, int'(bus.bl_y), 50);

    // Asynchronous reset in the middle of a sequence.
    bus.accel_x = 8'sd127;
    wait_update();
    wait_update();
    chk("ar_pre_x", 0, int'(bus.bl_x), 101);
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_bl_x", 0, int'(bus.bl_x), 100);
    chk("ar_bl_y", 0, int'(bus.bl_y), 50);
    chk("ar_update", 0, int'(bus.update), 0);
    check_release(1);
    chk("ar_post_x", 0, int'(bus.bl_x), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
